// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU operand stage: default datapath widths,
//   the ALU operation encodings and the legality check for captured ops.
package alu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int OP_W        = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b1010;
  localparam logic [OP_W-1:0] OP_AND = 4'b1100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1101;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0000;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0010;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if
//   Bundles every non-clock/reset signal of the operand stage.
//   master : decode, hazard control and forwarding sources (drives the
//            instruction, stall/flush and ex/wb fields; reads the stage outputs)
//   slave  : the operand stage itself
//   Decode side : in_valid, rs1/rs2 addr+data, imm, use_imm, alu_op_in,
//                 rd_addr_in, reg_write_in
//   Hazard side : stall, flush
//   Forwarding  : ex_we/ex_rd/ex_result, wb_we/wb_rd/wb_data
//   ALU side    : out_valid, data1, data2, alu_op, rd_addr, reg_write, illegal_op
interface alu_operand_stage_if
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
);

  logic               in_valid;
  logic [RADDR_W-1:0] rs1_addr;
  logic [RADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic [XLEN-1:0]    imm;
  logic               use_imm;
  logic [OP_W-1:0]    alu_op_in;
  logic [RADDR_W-1:0] rd_addr_in;
  logic               reg_write_in;

  logic               stall;
  logic               flush;

  logic               ex_we;
  logic [RADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]    ex_result;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;

  logic               out_valid;
  logic [XLEN-1:0]    data1;
  logic [XLEN-1:0]    data2;
  logic [OP_W-1:0]    alu_op;
  logic [RADDR_W-1:0] rd_addr;
  logic               reg_write;
  logic               illegal_op;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, use_imm,
           alu_op_in, rd_addr_in, reg_write_in, stall, flush,
           ex_we, ex_rd, ex_result, wb_we, wb_rd, wb_data,
    input  out_valid, data1, data2, alu_op, rd_addr, reg_write, illegal_op
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, use_imm,
           alu_op_in, rd_addr_in, reg_write_in, stall, flush,
           ex_we, ex_rd, ex_result, wb_we, wb_rd, wb_data,
    output out_valid, data1, data2, alu_op, rd_addr, reg_write, illegal_op
  );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux
//   Selects the value of one source operand from the EX result, the WB data
//   or the register-file read data. Register 0 always reads as zero.
//   Ports:
//     src_addr  : source register index
//     reg_data  : register-file read data for src_addr
//     ex_we/ex_rd/ex_result : instruction currently in the ALU
//     wb_we/wb_rd/wb_data   : instruction in writeback
//     sel_data  : selected operand value
module fwd_mux
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] src_addr,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               ex_we,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]    ex_result,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    sel_data
);

  logic src_zero;
  logic ex_hit;
  logic wb_hit;

  assign src_zero = (src_addr == '0);
  // A write to r0 is never a real producer, so it must not forward.
  assign ex_hit   = ex_we && (ex_rd != '0) && (ex_rd == src_addr);
  assign wb_hit   = wb_we && (wb_rd != '0) && (wb_rd == src_addr);

  always_comb begin
    sel_data = reg_data;
    if (src_zero) begin
      sel_data = '0;
    end else if (ex_hit) begin
      // EX holds the younger value, so it wins over WB.
      sel_data = ex_result;
    end else if (wb_hit) begin
      sel_data = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Pipeline register directly in front of the ALU. Forwards EX/WB results
//   into the decoded operands, selects immediate or register for operand 2,
//   and registers operands, op code and writeback control for the ALU.
//   Update priority per edge: flush > stall > load.
//   Ports:
//     clk   : stage clock, rising edge
//     rst_n : asynchronous active-low reset, clears all outputs
//     bus   : slave side of alu_operand_stage_if (decode, hazard,
//             forwarding inputs; registered ALU-side outputs)
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_operand_stage_if.slave bus
);

  logic [XLEN-1:0]    fwd1;
  logic [XLEN-1:0]    fwd2;
  logic [XLEN-1:0]    op2_sel;
  logic               op_legal;

  logic               out_valid_q;
  logic [XLEN-1:0]    data1_q;
  logic [XLEN-1:0]    data2_q;
  logic [OP_W-1:0]    alu_op_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic               reg_write_q;
  logic               illegal_op_q;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .src_addr  (bus.rs1_addr),
    .reg_data  (bus.rs1_data),
    .ex_we     (bus.ex_we),
    .ex_rd     (bus.ex_rd),
    .ex_result (bus.ex_result),
    .wb_we     (bus.wb_we),
    .wb_rd     (bus.wb_rd),
    .wb_data   (bus.wb_data),
    .sel_data  (fwd1)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .src_addr  (bus.rs2_addr),
    .reg_data  (bus.rs2_data),
    .ex_we     (bus.ex_we),
    .ex_rd     (bus.ex_rd),
    .ex_result (bus.ex_result),
    .wb_we     (bus.wb_we),
    .wb_rd     (bus.wb_rd),
    .wb_data   (bus.wb_data),
    .sel_data  (fwd2)
  );

  assign op2_sel  = bus.use_imm ? bus.imm : fwd2;
  assign op_legal = op_is_legal(bus.alu_op_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      alu_op_q     <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      illegal_op_q <= 1'b0;
    end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      // Bubble: payload fields are zeroed so a dead slot is recognisable
      // on a waveform; the sticky illegal flag is left alone.
      out_valid_q  <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      alu_op_q     <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_q <= 1'b1;
      data1_q     <= fwd1;
      data2_q     <= op2_sel;
      rd_addr_q   <= bus.rd_addr_in;
      // An unsupported op still occupies its slot but runs as a harmless ADD
      // with no register write.
      alu_op_q    <= op_legal ? bus.alu_op_in : OP_ADD;
      reg_write_q <= bus.reg_write_in && op_legal;
      if (!op_legal) begin
        illegal_op_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.data1      = data1_q;
  assign bus.data2      = data2_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.illegal_op = illegal_op_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_operand_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

  alu_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid     = 1'b0;
    bus.rs1_addr     = '0;
    bus.rs2_addr     = '0;
    bus.rs1_data     = '0;
    bus.rs2_data     = '0;
    bus.imm          = '0;
    bus.use_imm      = 1'b0;
    bus.alu_op_in    = OP_ADD;
    bus.rd_addr_in   = '0;
    bus.reg_write_in = 1'b0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.ex_we        = 1'b0;
    bus.ex_rd        = '0;
    bus.ex_result    = '0;
    bus.wb_we        = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
  endtask

  task automatic drive_inst(input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2,
                            input logic [3:0] op, input logic [4:0] rd,
                            input logic rw);
    bus.in_valid     = 1'b1;
    bus.rs1_addr     = rs1;
    bus.rs1_data     = d1;
    bus.rs2_addr     = rs2;
    bus.rs2_data     = d2;
    bus.alu_op_in    = op;
    bus.rd_addr_in   = rd;
    bus.reg_write_in = rw;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'h0);
    chk({tag, ".data1"},      bus.data1,           32'h0);
    chk({tag, ".data2"},      bus.data2,           32'h0);
    chk({tag, ".alu_op"},     32'(bus.alu_op),     32'h0);
    chk({tag, ".rd_addr"},    32'(bus.rd_addr),    32'h0);
    chk({tag, ".reg_write"},  32'(bus.reg_write),  32'h0);
    chk({tag, ".illegal_op"}, 32'(bus.illegal_op), 32'h0);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
    #1;
    chk_all_zero("por");

    // --- reset asserted mid-operation, no edge needed ---
    step();
    rst_n = 1'b1;
    drive_inst(5'd1, 32'h1234, 5'd2, 32'h5678, OP_OR, 5'd9, 1'b1);
    step();
    chk("pre_rst.data1", bus.data1, 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    drive_inst(5'd1, 32'd5, 5'd2, 32'd7, OP_ADD, 5'd3, 1'b1);
    step();
    chk("add.data1",     bus.data1,           32'd5);
    chk("add.data2",     bus.data2,           32'd7);
    chk("add.alu_op",    32'(bus.alu_op),     32'h8);
    chk("add.out_valid", 32'(bus.out_valid),  32'h1);
    chk("add.reg_write", 32'(bus.reg_write),  32'h1);
    chk("add.rd_addr",   32'(bus.rd_addr),    32'd3);

    // --- forwarding priority ---
    drive_inst(5'd3, 32'h33, 5'd6, 32'h66, OP_ADD, 5'd4, 1'b1);
    bus.ex_we = 1'b1; bus.ex_rd = 5'd3; bus.ex_result = 32'h11;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data   = 32'h22;
    step();
    chk("fwd_ex.data1", bus.data1, 32'h11);
    chk("fwd_ex.data2", bus.data2, 32'h66);
    bus.ex_we    = 1'b0;
    bus.rs2_addr = 5'd3;
    step();
    chk("fwd_wb.data1", bus.data1, 32'h22);
    chk("fwd_wb.data2", bus.data2, 32'h22);
    bus.ex_we    = 1'b1; bus.ex_rd = 5'd0;
    bus.rs1_addr = 5'd0;
    bus.wb_rd    = 5'd0;
    step();
    chk("fwd_r0.data1", bus.data1, 32'h0);

    // --- immediate select ignores forwarding ---
    clear_inputs();
    drive_inst(5'd1, 32'h10, 5'd5, 32'h50, OP_ADD, 5'd6, 1'b1);
    bus.use_imm = 1'b1; bus.imm = 32'hFFFF_FFFC;
    bus.wb_we   = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h55;
    step();
    chk("imm.data2", bus.data2, 32'hFFFF_FFFC);
    chk("imm.data1", bus.data1, 32'h10);

    // --- stall holds, stall+flush bubbles ---
    clear_inputs();
    drive_inst(5'd1, 32'h100, 5'd2, 32'h30, OP_SUB, 5'd7, 1'b1);
    step();
    chk("sub.alu_op", 32'(bus.alu_op), 32'hA);
    chk("sub.data1",  bus.data1,       32'h100);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_inst(5'd1, 32'hA0 + 32'(i), 5'd2, 32'hB0, OP_AND, 5'd8, 1'b0);
      bus.ex_we = 1'b1; bus.ex_rd = 5'd1; bus.ex_result = 32'hEE;
      step();
      chk("stall.data1",     bus.data1,          32'h100);
      chk("stall.data2",     bus.data2,          32'h30);
      chk("stall.alu_op",    32'(bus.alu_op),    32'hA);
      chk("stall.rd_addr",   32'(bus.rd_addr),   32'd7);
      chk("stall.reg_write", 32'(bus.reg_write), 32'h1);
      chk("stall.out_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.flush = 1'b1;
    step();
    chk("flush.out_valid", 32'(bus.out_valid), 32'h0);
    chk("flush.reg_write", 32'(bus.reg_write), 32'h0);
    chk("flush.data1",     bus.data1,          32'h0);

    // --- illegal op: sticky until reset ---
    clear_inputs();
    drive_inst(5'd1, 32'h1, 5'd2, 32'h2, 4'b0111, 5'd4, 1'b1);
    step();
    chk("ill.alu_op",     32'(bus.alu_op),     32'h8);
    chk("ill.reg_write",  32'(bus.reg_write),  32'h0);
    chk("ill.out_valid",  32'(bus.out_valid),  32'h1);
    chk("ill.illegal_op", 32'(bus.illegal_op), 32'h1);
    drive_inst(5'd1, 32'h1, 5'd2, 32'h2, OP_OR, 5'd4, 1'b1);
    step();
    chk("legal_after.alu_op",     32'(bus.alu_op),     32'hD);
    chk("legal_after.reg_write",  32'(bus.reg_write),  32'h1);
    chk("legal_after.illegal_op", 32'(bus.illegal_op), 32'h1);
    bus.flush = 1'b1;
    step();
    chk("flush_ill.illegal_op", 32'(bus.illegal_op), 32'h1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("bubble.out_valid",  32'(bus.out_valid),  32'h0);
    chk("bubble.reg_write",  32'(bus.reg_write),  32'h0);
    chk("bubble.illegal_op", 32'(bus.illegal_op), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_ill.illegal_op", 32'(bus.illegal_op), 32'h0);
    rst_n = 1'b1;

    // --- back-to-back dependent ADDs, ex_* from a reference ALU ---
    clear_inputs();
    drive_inst(5'd3, 32'd10, 5'd4, 32'd20, OP_ADD, 5'd1, 1'b1);
    step();
    chk("dep1.data1", bus.data1, 32'd10);
    chk("dep1.data2", bus.data2, 32'd20);
    bus.ex_we     = bus.reg_write;
    bus.ex_rd     = bus.rd_addr;
    bus.ex_result = ref_alu(bus.alu_op, bus.data1, bus.data2);
    drive_inst(5'd1, 32'hDEAD, 5'd2, 32'd4, OP_ADD, 5'd2, 1'b1);
    step();
    chk("dep2.data1",   bus.data1,        32'd30);
    chk("dep2.data2",   bus.data2,        32'd4);
    chk("dep2.rd_addr", 32'(bus.rd_addr), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline register stage directly upstream of the ALU.
- Captures decoded operands, selects register or immediate for operand 2, and applies EX/WB forwarding before the capture edge.
- Presents registered data1/data2/ALUop to the combinational ALU, and carries rd/reg_write alongside for writeback.
- Supports stall (hold) and flush (bubble) from hazard control.

Parameters:
- XLEN, 32, datapath width; must equal the ALU operand width.
- RADDR_W, 5, register address width; register 0 is hardwired zero.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode presents a valid instruction.
- rs1_addr  input  RADDR_W  source 1 register index.
- rs2_addr  input  RADDR_W  source 2 register index.
- rs1_data  input  XLEN  register-file read data, source 1.
- rs2_data  input  XLEN  register-file read data, source 2.
- imm  input  XLEN  sign-extended immediate.
- use_imm  input  1  1 selects imm as operand 2; rs2 forwarding is then ignored.
- alu_op_in  input  4  ALU operation code.
- rd_addr_in  input  RADDR_W  destination register index.
- reg_write_in  input  1  instruction writes rd.
- stall  input  1  hold stage contents.
- flush  input  1  insert a bubble.
- ex_we  input  1  instruction currently in ALU writes a register.
- ex_rd  input  RADDR_W  its destination.
- ex_result  input  XLEN  current ALU result (combinational).
- wb_we  input  1  writeback stage writes a register.
- wb_rd  input  RADDR_W  writeback destination.
- wb_data  input  XLEN  writeback data.
- out_valid  output  1  registered outputs hold a valid instruction.
- data1  output  XLEN  ALU operand 1.
- data2  output  XLEN  ALU operand 2.
- alu_op  output  4  ALU operation.
- rd_addr  output  RADDR_W  destination passed to EX.
- reg_write  output  1  write enable passed to EX; always 0 when out_valid=0.
- illegal_op  output  1  sticky flag: an unsupported ALU op was captured.

Behaviour:
- Reset: the stage is held in reset while rst_n=0 and enters reset asynchronously. All outputs are 0 in reset: out_valid, data1, data2, alu_op, rd_addr, reg_write, illegal_op.
- Update priority at each clock edge: flush > stall > load.
- Flush: out_valid=0 and reg_write=0. data1, data2, alu_op and rd_addr are don't-care but are zeroed. illegal_op is unchanged.
- Stall (without flush): all registers hold their values, including forwarded operands.
- Load: out_valid <= in_valid; reg_write <= reg_write_in & in_valid. Other fields load from the forwarded or selected values below.
- Forwarding for operand 1, evaluated combinationally before the edge:
  - If ex_we and ex_rd != 0 and ex_rd == rs1_addr, use ex_result.
  - Else, if wb_we and wb_rd != 0 and wb_rd == rs1_addr, use wb_data.
  - Else, use rs1_data.
  - EX has priority over WB.
- Operand 1 with rs1_addr == 0: always 0, regardless of rs1_data or forwarding.
- Operand 2: same forwarding rules applied to rs2. If use_imm=1, operand 2 is imm and forwarding is ignored.
- Supported ALU ops: 1000 ADD, 1010 SUB, 1100 AND, 1101 OR, 0000 SLL, 0010 SRL.
- Unsupported alu_op_in captured with in_valid=1:
  - alu_op is loaded as ADD (1000) and reg_write as 0.
  - out_valid=1 is kept, so the slot still flows.
  - illegal_op sets to 1 and stays set until reset.
- Latency: exactly 1 cycle from capture to outputs. No combinational path from any input to any output.
- in_valid=0 on load: produces a bubble, same as flush but illegal_op is not checked.
- Simultaneous ex and wb match on the same register: EX wins.
- Reset asserted mid-stall: the stage clears immediately. After reset release, the first edge loads normally.

Decomposition:
- Shared package alu_pkg holds:
  - XLEN and RADDR_W defaults.
  - ALU op constants: OP_ADD=1000, OP_SUB=1010, OP_AND=1100, OP_OR=1101, OP_SLL=0000, OP_SRL=0010.
  - Function op_is_legal.
- One natural sub-module: fwd_mux, instantiated twice (rs1, rs2).
  - Inputs: src addr, reg data, ex/wb forwarding fields.
  - Output: the selected value.

Test Plan:
- Reset check: assert rst_n=0 mid-operation, with no clock edge -> all outputs 0 immediately. Release, load ADD with rs1_data=5, rs2_data=7 -> next edge data1=5, data2=7, alu_op=1000, out_valid=1.
- Forwarding priority: rs1=3; ex_we=1, ex_rd=3, ex_result=0x11; wb_we=1, wb_rd=3, wb_data=0x22; rs1_data=0x33 -> data1=0x11. Drop ex_we -> data1=0x22. Set ex_rd=0 with rs1=0 -> data1=0.
- Immediate select: use_imm=1, imm=0xFFFFFFFC, wb forwarding matching rs2 -> data2=0xFFFFFFFC.
- Stall then flush: load SUB; assert stall for 3 cycles while inputs change -> outputs unchanged. Assert stall and flush together -> out_valid=0, reg_write=0.
- Illegal op: alu_op_in=0111, in_valid=1, reg_write_in=1 -> alu_op=1000, reg_write=0, out_valid=1, illegal_op=1. Next legal op keeps illegal_op=1 until reset.
- Back-to-back dependent instructions: ADD r1 then ADD r2 using r1, with ex_* driven from a reference ALU -> the second instruction's data1 equals the first instruction's result.
